vec_packer: RTL and testbench
=============================

VEC_PACKER -- requirements
Module: vec_packer

Interface
REQ-001 The block SHALL have parameter ELEM_W, default 8, giving the element width in bits.
REQ-002 The block SHALL have parameter NUM_ELEM, default 4, giving elements per packed vector (power of two, >= 2).
REQ-003 Port clk, input, 1 bit, SHALL be the clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-005 Port recv_msg, input, ELEM_W bits, SHALL carry one element from the upstream element queue.
REQ-006 Port recv_val, input, 1 bit, SHALL indicate that recv_msg is valid.
REQ-007 Port recv_rdy, output, 1 bit, SHALL indicate that the block can accept an element this cycle.
REQ-008 Port flush, input, 1 bit, SHALL request emission of a partially filled vector.
REQ-009 Port send_msg, output, ELEM_W*NUM_ELEM bits, SHALL carry the packed vector; element i sits at bits [i*ELEM_W +: ELEM_W].
REQ-010 Port send_mask, output, NUM_ELEM bits, SHALL mark valid lanes; bit i set means element i is valid.
REQ-011 Port send_val, output, 1 bit, SHALL indicate that send_msg/send_mask are valid.
REQ-012 Port send_rdy, input, 1 bit, SHALL indicate that downstream accepts the vector this cycle.

Function
REQ-013 The block SHALL implement two states: FILL (collecting) and HOLD (presenting output).
REQ-014 Signal recv_rdy SHALL be 1 exactly when the state is FILL, with no combinational path from any input.
REQ-015 Signal send_val SHALL be 1 exactly when the state is HOLD, with no combinational path from any input.
REQ-016 A recv transfer (recv_val and recv_rdy) SHALL write recv_msg into lane cnt, set mask bit cnt, and increment the lane counter cnt (width clog2(NUM_ELEM)).
REQ-017 When a recv transfer fills lane NUM_ELEM-1, the block SHALL enter HOLD on the next edge, with cnt wrapping to 0.
REQ-018 Latency from acceptance of the last element to send_val=1 SHALL be exactly 1 cycle.
REQ-019 If flush=1 in FILL with cnt>0 or a concurrent recv transfer, the block SHALL enter HOLD next edge; any concurrent element is included.
REQ-020 If flush=1 in FILL with cnt=0 and no recv transfer, the flush SHALL be ignored with no state change.
REQ-021 The flush input SHALL be ignored in HOLD.
REQ-022 In HOLD, send_msg and send_mask SHALL stay stable until a send transfer (send_val and send_rdy) occurs.
REQ-023 On a send transfer, the block SHALL return to FILL next edge, with cnt=0 and all data lanes and mask cleared to 0.
REQ-024 Unfilled lanes of send_msg SHALL read 0 (for example, after a partial flush).
REQ-025 Throughput SHALL be one full vector per NUM_ELEM+1 cycles under continuous val/rdy; there is one bubble cycle in HOLD.
REQ-026 Elements SHALL never be dropped, duplicated or reordered; element order equals lane index order.

Reset
REQ-027 While reset=1, the block SHALL force state=FILL, cnt=0, data lanes=0 and mask=0, giving recv_rdy=1, send_val=0, send_msg=0 and send_mask=0.
REQ-028 Reset asserted mid-vector or in HOLD SHALL discard all partial or pending data immediately, without waiting for a clock edge.
REQ-029 After reset deasserts, the first recv transfer SHALL land in lane 0.

Verification
REQ-030 Full pack: recv 0x11,0x22,0x33,0x44 on consecutive cycles, send_rdy=1 -> send_val=1 one cycle after 0x44 with send_msg=0x44332211, send_mask=4'b1111, then recv_rdy=1 next cycle.
REQ-031 Backpressure: fill 0xA1..0xA4, hold send_rdy=0 for 5 cycles -> send_val=1, send_msg=0xA4A3A2A1 stable, recv_rdy=0 throughout; send_rdy=1 -> FILL next cycle.
REQ-032 Partial flush: recv 0x55,0x66, then flush=1 with recv_val=0 -> send_msg=0x00006655, send_mask=4'b0011.
REQ-033 Flush concurrent with recv: cnt=2 (0x01,0x02), recv 0x03 with flush=1 -> send_msg=0x00030201, send_mask=4'b0111.
REQ-034 Empty flush ignored: after reset, flush=1 for 3 cycles, recv_val=0 -> send_val stays 0, recv_rdy stays 1.
REQ-035 Reset mid-operation: accept 0x77,0x88, assert reset asynchronously -> send_val=0, mask=0 immediately; after release, recv 0x99..0xCC -> send_msg=0xCCBBAA99.

Source files
------------

// File: rtl/vec_packer_if.sv
// Handshake bundle for vec_packer: element stream in, packed vector out.
// Ports: recv_msg/recv_val/recv_rdy, flush, send_msg/send_mask/send_val/send_rdy.
interface vec_packer_if #(
   parameter int ELEM_W   = 8,
   parameter int NUM_ELEM = 4
);
   logic [ELEM_W-1:0]          recv_msg;
   logic                       recv_val;
   logic                       recv_rdy;
   logic                       flush;
   logic [ELEM_W*NUM_ELEM-1:0] send_msg;
   logic [NUM_ELEM-1:0]        send_mask;
   logic                       send_val;
   logic                       send_rdy;

   // environment side: feeds elements, consumes vectors
   modport master (
      output recv_msg,
      output recv_val,
      output flush,
      output send_rdy,
      input  recv_rdy,
      input  send_msg,
      input  send_mask,
      input  send_val
   );

   // packer side
   modport slave (
      input  recv_msg,
      input  recv_val,
      input  flush,
      input  send_rdy,
      output recv_rdy,
      output send_msg,
      output send_mask,
      output send_val
   );
endinterface

// File: rtl/vec_packer.sv
// Packs NUM_ELEM elements of ELEM_W bits into one vector with lane mask.
// Ports: clk, reset (async, active-high), bus (vec_packer_if.slave).
module vec_packer #(
   parameter int ELEM_W   = 8,
   parameter int NUM_ELEM = 4
) (
   input logic         clk,
   input logic         reset,
   vec_packer_if.slave bus
);
   localparam int CW = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
   localparam int VW = ELEM_W * NUM_ELEM;
   localparam logic [CW-1:0] LAST = CW'(NUM_ELEM - 1);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [VW-1:0]       data;
   logic [NUM_ELEM-1:0] mask;
   logic                rdy_q;
   logic                val_q;

   logic recv_fire;
   logic send_fire;
   logic last_lane;
   logic go_hold;

   assign recv_fire = bus.recv_val & rdy_q;
   assign send_fire = bus.send_rdy & val_q;
   assign last_lane = (cnt == LAST);

   // A flush with nothing collected and nothing arriving is a no-op,
   // so an empty vector is never presented.
   assign go_hold = recv_fire
                  ? (last_lane | bus.flush)
                  : (rdy_q & bus.flush & (cnt != '0));

   // Handshake flags are registered copies of the state so neither
   // ready nor valid depends combinationally on any input.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FILL;
         cnt   <= '0;
         data  <= '0;
         mask  <= '0;
         rdy_q <= 1'b1;
         val_q <= 1'b0;
      end else begin
         unique case (state)
            FILL: begin
               if (recv_fire) begin
                  data[cnt*ELEM_W +: ELEM_W] <= bus.recv_msg;
                  mask[cnt] <= 1'b1;
                  cnt       <= cnt + CW'(1);
               end
               if (go_hold) begin
                  state <= HOLD;
                  cnt   <= '0;
                  rdy_q <= 1'b0;
                  val_q <= 1'b1;
               end
            end
            HOLD: begin
               if (send_fire) begin
                  state <= FILL;
                  cnt   <= '0;
                  data  <= '0;
                  mask  <= '0;
                  rdy_q <= 1'b1;
                  val_q <= 1'b0;
               end
            end
            default: begin
               state <= FILL;
               cnt   <= '0;
               data  <= '0;
               mask  <= '0;
               rdy_q <= 1'b1;
               val_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.recv_rdy  = rdy_q;
   assign bus.send_val  = val_q;
   assign bus.send_msg  = data;
   assign bus.send_mask = mask;
endmodule

// File: tb/tb_vec_packer.sv
// Directed self-checking bench for vec_packer.
// Drives and samples on the falling edge; DUT updates on the rising edge.
module tb_vec_packer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   vec_packer_if #(.ELEM_W(8), .NUM_ELEM(4)) bus ();

   vec_packer #(.ELEM_W(8), .NUM_ELEM(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push(input logic [7:0] b);
      bus.recv_msg = b;
      bus.recv_val = 1'b1;
      tick();
      bus.recv_val = 1'b0;
      bus.recv_msg = 8'h00;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      n_checks++;
      if (bus.recv_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_recv_rdy got %b want 1", bus.recv_rdy);
      end
      n_checks++;
      if (bus.send_val !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_send_val got %b want 0", bus.send_val);
      end
      n_checks++;
      if (bus.send_msg !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_send_msg got %h want 0", bus.send_msg);
      end
      n_checks++;
      if (bus.send_mask !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_send_mask got %b want 0000",
                  bus.send_mask);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_full_pack();
      bus.send_rdy = 1'b1;
      push(8'h11);
      push(8'h22);
      push(8'h33);
      n_checks++;
      if (bus.send_val !== 1'b0) begin
         n_fail++;
         $display("FAIL full_early_val got %b want 0", bus.send_val);
      end
      push(8'h44);
      n_checks++;
      if (bus.send_val !== 1'b1) begin
         n_fail++;
         $display("FAIL full_send_val got %b want 1", bus.send_val);
      end
      n_checks++;
      if (bus.send_msg !== 32'h44332211) begin
         n_fail++;
         $display("FAIL full_send_msg got %h want 44332211",
                  bus.send_msg);
      end
      n_checks++;
      if (bus.send_mask !== 4'b1111) begin
         n_fail++;
         $display("FAIL full_send_mask got %b want 1111",
                  bus.send_mask);
      end
      n_checks++;
      if (bus.recv_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL full_hold_rdy got %b want 0", bus.recv_rdy);
      end
      tick();
      n_checks++;
      if (bus.recv_rdy !== 1'b1 || bus.send_val !== 1'b0) begin
         n_fail++;
         $display("FAIL full_return got rdy=%b val=%b want 1/0",
                  bus.recv_rdy, bus.send_val);
      end
      n_checks++;
      if (bus.send_msg !== 32'h0 || bus.send_mask !== 4'b0) begin
         n_fail++;
         $display("FAIL full_cleared got %h/%b want 0/0",
                  bus.send_msg, bus.send_mask);
      end
   endtask

   task automatic test_backpressure();
      bus.send_rdy = 1'b0;
      push(8'hA1);
      push(8'hA2);
      push(8'hA3);
      push(8'hA4);
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (bus.send_val !== 1'b1 || bus.recv_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_flags[%0d] got val=%b rdy=%b want 1/0",
                     i, bus.send_val, bus.recv_rdy);
         end
         n_checks++;
         if (bus.send_msg !== 32'hA4A3A2A1) begin
            n_fail++;
            $display("FAIL bp_msg[%0d] got %h want a4a3a2a1",
                     i, bus.send_msg);
         end
         // offered elements must not be taken while holding
         bus.recv_val = 1'b1;
         bus.recv_msg = 8'hEE;
         bus.flush = 1'b1;
         tick();
         bus.recv_val = 1'b0;
         bus.flush = 1'b0;
      end
      n_checks++;
      if (bus.send_msg !== 32'hA4A3A2A1 || bus.send_mask !== 4'hF) begin
         n_fail++;
         $display("FAIL bp_final got %h/%b want a4a3a2a1/1111",
                  bus.send_msg, bus.send_mask);
      end
      bus.send_rdy = 1'b1;
      tick();
      n_checks++;
      if (bus.recv_rdy !== 1'b1 || bus.send_val !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release got rdy=%b val=%b want 1/0",
                  bus.recv_rdy, bus.send_val);
      end
   endtask

   task automatic test_partial_flush();
      bus.send_rdy = 1'b0;
      push(8'h55);
      push(8'h66);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      n_checks++;
      if (bus.send_val !== 1'b1) begin
         n_fail++;
         $display("FAIL pflush_val got %b want 1", bus.send_val);
      end
      n_checks++;
      if (bus.send_msg !== 32'h00006655) begin
         n_fail++;
         $display("FAIL pflush_msg got %h want 00006655", bus.send_msg);
      end
      n_checks++;
      if (bus.send_mask !== 4'b0011) begin
         n_fail++;
         $display("FAIL pflush_mask got %b want 0011", bus.send_mask);
      end
      bus.send_rdy = 1'b1;
      tick();
      // next vector must start again from lane 0
      push(8'hD0);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      n_checks++;
      if (bus.send_msg !== 32'h000000D0 || bus.send_mask !== 4'b0001) begin
         n_fail++;
         $display("FAIL pflush_restart got %h/%b want 000000d0/0001",
                  bus.send_msg, bus.send_mask);
      end
      tick();
   endtask

   task automatic test_flush_concurrent();
      bus.send_rdy = 1'b0;
      push(8'h01);
      push(8'h02);
      bus.recv_msg = 8'h03;
      bus.recv_val = 1'b1;
      bus.flush = 1'b1;
      tick();
      bus.recv_val = 1'b0;
      bus.flush = 1'b0;
      n_checks++;
      if (bus.send_val !== 1'b1) begin
         n_fail++;
         $display("FAIL cflush_val got %b want 1", bus.send_val);
      end
      n_checks++;
      if (bus.send_msg !== 32'h00030201) begin
         n_fail++;
         $display("FAIL cflush_msg got %h want 00030201", bus.send_msg);
      end
      n_checks++;
      if (bus.send_mask !== 4'b0111) begin
         n_fail++;
         $display("FAIL cflush_mask got %b want 0111", bus.send_mask);
      end
      bus.send_rdy = 1'b1;
      tick();
   endtask

   task automatic test_empty_flush();
      do_reset();
      bus.flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (bus.send_val !== 1'b0 || bus.recv_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL eflush[%0d] got val=%b rdy=%b want 0/1",
                     i, bus.send_val, bus.recv_rdy);
         end
      end
      bus.flush = 1'b0;
      // single element after ignored flushes still lands in lane 0
      bus.send_rdy = 1'b0;
      push(8'h5A);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      n_checks++;
      if (bus.send_msg !== 32'h0000005A || bus.send_mask !== 4'b0001) begin
         n_fail++;
         $display("FAIL eflush_after got %h/%b want 0000005a/0001",
                  bus.send_msg, bus.send_mask);
      end
      bus.send_rdy = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid();
      bus.send_rdy = 1'b1;
      push(8'h77);
      push(8'h88);
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (bus.send_val !== 1'b0 || bus.send_mask !== 4'b0000) begin
         n_fail++;
         $display("FAIL rmid_async got val=%b mask=%b want 0/0000",
                  bus.send_val, bus.send_mask);
      end
      tick();
      reset = 1'b0;
      tick();
      // reset while holding a full vector
      bus.send_rdy = 1'b0;
      push(8'h01);
      push(8'h02);
      push(8'h03);
      push(8'h04);
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (bus.send_val !== 1'b0 || bus.recv_rdy !== 1'b1 ||
          bus.send_msg !== 32'h0) begin
         n_fail++;
         $display("FAIL rhold_async got val=%b rdy=%b msg=%h want 0/1/0",
                  bus.send_val, bus.recv_rdy, bus.send_msg);
      end
      tick();
      reset = 1'b0;
      tick();
      bus.send_rdy = 1'b0;
      push(8'h99);
      push(8'hAA);
      push(8'hBB);
      push(8'hCC);
      n_checks++;
      if (bus.send_msg !== 32'hCCBBAA99 || bus.send_mask !== 4'hF) begin
         n_fail++;
         $display("FAIL rmid_after got %h/%b want ccbbaa99/1111",
                  bus.send_msg, bus.send_mask);
      end
      bus.send_rdy = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      bus.send_rdy = 1'b1;
      push(8'h10);
      push(8'h20);
      push(8'h30);
      push(8'h40);
      n_checks++;
      if (bus.send_msg !== 32'h40302010) begin
         n_fail++;
         $display("FAIL b2b_first got %h want 40302010", bus.send_msg);
      end
      tick();
      push(8'h50);
      push(8'h60);
      push(8'h70);
      push(8'h80);
      n_checks++;
      if (bus.send_val !== 1'b1 || bus.send_msg !== 32'h80706050) begin
         n_fail++;
         $display("FAIL b2b_second got val=%b msg=%h want 1/80706050",
                  bus.send_val, bus.send_msg);
      end
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bus.recv_msg = 8'h00;
      bus.recv_val = 1'b0;
      bus.flush    = 1'b0;
      bus.send_rdy = 1'b0;
      test_reset();
      test_full_pack();
      test_backpressure();
      test_partial_flush();
      test_flush_concurrent();
      test_empty_flush();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
